// File: rtl/imm_gen_pipe.sv
// Immediate generator for RV32I/RV64I decode. It decodes the I/S/B/U/J formats,
// sign-extends the result to XLEN and presents it behind a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]      opcode;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    entry_t          dec;

    assign opcode = in_instr[6:0];

    always_comb begin
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        unique case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
            7'b0011011: begin
                if (XLEN == 64) dec_fmt = FMT_I;
                else            dec_ill = 1'b1;
            end
            7'b0100011:             dec_fmt = FMT_S;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            7'b0110011, 7'b0001111, 7'b1110011: dec_fmt = FMT_NONE;
            7'b0111011: dec_ill = (XLEN != 64);
            default:    dec_ill = 1'b1;
        endcase
    end

    // Every format fits in 32 bits with instr[31] as sign, so build it there first.
    always_comb begin
        imm32 = '0;
        unique case (dec_fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_ext
            assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_noext
            assign dec_imm = imm32[XLEN-1:0];
        end
    endgenerate

    always_comb begin
        dec.imm     = dec_imm;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_ill;
        dec.tag     = in_tag;
    end

    entry_t or_q, or_d, sk_q, sk_d;
    logic   or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic   accept;

    assign in_ready = !sk_vld_q;
    assign accept   = in_valid && in_ready;

    // The skid entry has priority for a free output slot. While it is full,
    // in_ready is low, so a new accept can only reach OR when SK is empty.
    always_comb begin
        or_d     = or_q;
        sk_d     = sk_q;
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || out_ready) begin
            if (sk_vld_q) begin
                or_d     = sk_q;
                or_vld_d = 1'b1;
                sk_vld_d = 1'b0;
            end else if (accept) begin
                or_d     = dec;
                or_vld_d = 1'b1;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (accept) begin
            sk_d     = dec;
            sk_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            or_q     <= '0;
            sk_q     <= '0;
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
        end else begin
            or_q     <= or_d;
            sk_q     <= sk_d;
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
        end
    end

    assign out_valid   = or_vld_q;
    assign out_imm     = or_q.imm;
    assign out_fmt     = or_q.fmt;
    assign out_illegal = or_q.illegal;
    assign out_tag     = or_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. An XLEN=64 instance and an XLEN=32 instance
// share the same stimulus and are checked against an arithmetic reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag));

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32));

    typedef struct {
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sgn(input logic b, input int w);
        return b ? -(longint'(1) << w) : longint'(0);
    endfunction

    // Immediate as a signed integer built from weighted bit fields.
    function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        logic [6:0] op;
        longint v;
        op  = ins[6:0];
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        if (op inside {7'h03, 7'h13, 7'h67} || (xlen == 64 && op == 7'h1B)) fmt = 3'd1;
        else if (op == 7'h23) fmt = 3'd2;
        else if (op == 7'h63) fmt = 3'd3;
        else if (op inside {7'h37, 7'h17}) fmt = 3'd4;
        else if (op == 7'h6F) fmt = 3'd5;
        else if (!(op inside {7'h33, 7'h0F, 7'h73} || (xlen == 64 && op == 7'h3B))) ill = 1'b1;
        case (fmt)
            3'd1: v = longint'(ins[30:20]) + sgn(ins[31], 11);
            3'd2: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) + sgn(ins[31], 11);
            3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 + sgn(ins[31], 12);
            3'd4: v = longint'(ins[30:12]) * 4096 + sgn(ins[31], 31);
            3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 + sgn(ins[31], 20);
            default: v = 0;
        endcase
        imm = v;
    endfunction

    task automatic push_exp(input logic [31:0] ins, input logic [7:0] tag);
        exp_t e;
        logic [63:0] i32;
        ref_dec(ins, 64, e.imm64, e.fmt64, e.ill64);
        ref_dec(ins, 32, i32, e.fmt32, e.ill32);
        e.imm32 = i32[31:0];
        e.tag   = tag;
        q.push_back(e);
    endtask

    // One clock: record acceptance at the negedge, return just after the next posedge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !flush && !reset;
        if (acc) push_exp(in_instr, in_tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send(input logic [31:0] ins, input logic [7:0] tag);
        bit a;
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) step(a);
        chk("send_accepted", 64'(a), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_out_imm"}, out_imm, 64'd0);
        chk({name, "_out_fmt"}, 64'(out_fmt), 64'd0);
        chk({name, "_out_illegal"}, 64'(out_illegal), 64'd0);
        chk({name, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({name, "_out_valid32"}, 64'(out_valid32), 64'd0);
        chk({name, "_out_imm32"}, 64'(out_imm32), 64'd0);
    endtask

    // Monitor: runs mid-cycle, before the driver records this cycle's accept.
    logic        stalled = 1'b0;
    logic [63:0] prev_imm;
    logic [7:0]  prev_tag;
    logic [2:0]  prev_fmt;
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (reset) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                chk("in_ready_vs_occupancy", 64'(in_ready), 64'(q.size() < 2));
                chk("out_valid_vs_occupancy", 64'(out_valid), 64'(q.size() > 0));
                chk("out_valid_32_vs_64", 64'(out_valid32), 64'(out_valid));
                if (stalled) begin
                    chk("stall_valid_held", 64'(out_valid), 64'd1);
                    chk("stall_imm_held", out_imm, prev_imm);
                    chk("stall_tag_held", 64'(out_tag), 64'(prev_tag));
                    chk("stall_fmt_held", 64'(out_fmt), 64'(prev_fmt));
                end
                if (out_valid && out_ready && !flush && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("imm64", out_imm, e.imm64);
                    chk("fmt64", 64'(out_fmt), 64'(e.fmt64));
                    chk("ill64", 64'(out_illegal), 64'(e.ill64));
                    chk("tag64", 64'(out_tag), 64'(e.tag));
                    chk("imm32", 64'(out_imm32), 64'(e.imm32));
                    chk("fmt32", 64'(out_fmt32), 64'(e.fmt32));
                    chk("ill32", 64'(out_illegal32), 64'(e.ill32));
                    chk("tag32", 64'(out_tag32), 64'(e.tag));
                end
                if (flush) q.delete();
                stalled  = out_valid && !out_ready && !flush;
                prev_imm = out_imm;
                prev_tag = out_tag;
                prev_fmt = out_fmt;
            end
        end
    end

    logic [6:0] ops [15] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F, 7'h0B};

    initial begin
        bit a;
        logic [31:0] r;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        @(posedge clk); #1;
        idle(2);
        reset = 1'b0;
        chk_zero_outputs("reset");

        // Single-cycle latency on an empty buffer.
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h01;
        step(a);
        in_valid = 1'b0;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_fmt", 64'(out_fmt), 64'd1);
        chk("addi_illegal", 64'(out_illegal), 64'd0);
        idle(1);

        // Back-to-back stream, one per cycle.
        in_valid = 1'b1;
        in_instr = 32'hFE112E23; in_tag = 8'h10; step(a); chk("stream_acc0", 64'(a), 64'd1);
        chk("sw_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        in_instr = 32'hFE000CE3; in_tag = 8'h11; step(a); chk("stream_acc1", 64'(a), 64'd1);
        chk("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFF8);
        in_instr = 32'h001000EF; in_tag = 8'h12; step(a); chk("stream_acc2", 64'(a), 64'd1);
        chk("jal_imm", out_imm, 64'h0000000000000800);
        chk("jal_fmt", 64'(out_fmt), 64'd5);
        in_valid = 1'b0;
        idle(1);

        send(32'h800002B7, 8'h20);
        chk("lui_imm64", out_imm, 64'hFFFFFFFF80000000);
        chk("lui_imm32", 64'(out_imm32), 64'h80000000);
        chk("lui_fmt", 64'(out_fmt), 64'd4);
        send(32'h0000001B, 8'h21);
        chk("opimm32_ill64", 64'(out_illegal), 64'd0);
        chk("opimm32_ill32", 64'(out_illegal32), 64'd1);
        send(32'h0000007F, 8'h22);
        chk("op7f_ill", 64'(out_illegal), 64'd1);
        send(32'h00000000, 8'h23);
        chk("zero_ill", 64'(out_illegal), 64'd1);
        send(32'h00000033, 8'h24);
        chk("add_ill", 64'(out_illegal), 64'd0);
        idle(1);

        // Backpressure: A to OR, B to SK, C held upstream.
        out_ready = 1'b0;
        send(32'h00500093, 8'hA0);
        send(32'h00600113, 8'hB0);
        in_valid = 1'b1; in_instr = 32'h00700193; in_tag = 8'hC0;
        idle(3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_tag", 64'(out_tag), 64'hA0);
        out_ready = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) step(a);
        chk("bp_c_accepted", 64'(a), 64'd1);
        in_valid = 1'b0;
        idle(4);

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        send(32'h00100093, 8'hD0);
        send(32'h00200093, 8'hD1);
        in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 8'hD2; flush = 1'b1;
        step(a);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(3);

        // Same with reset.
        out_ready = 1'b0;
        send(32'hFFF00093, 8'hE0);
        send(32'h800002B7, 8'hE1);
        in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 8'hE2; reset = 1'b1;
        step(a);
        reset = 1'b0; in_valid = 1'b0;
        chk_zero_outputs("midreset");
        out_ready = 1'b1;
        idle(2);

        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = {r[31:7], ops[$urandom_range(0, 14)]};
            if ($urandom_range(0, 15) == 0) in_instr[1:0] = r[1:0];
            in_tag    = 8'($urandom());
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step(a);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(5);
        chk("drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Decodes every base RV32I/RV64I immediate format (I, S, B, U, J) and sign-extends to XLEN.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without losing an instruction.
- Sits between fetch/IF-ID and the register-read/control stage; supports a pipeline flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. OP-IMM-32 (0011011) is only recognised when XLEN=64.
- TAG_W, 8, width of the opaque sideband tag (e.g. PC index) carried alongside each instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drops all buffered entries and any input accepted this cycle.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  out_imm, out_fmt, out_illegal and out_tag are valid.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_illegal  out  1  instr[1:0]!=11, or opcode not in the table below.
- out_tag  out  TAG_W  tag of the entry being presented.

Behaviour:
- Decode is combinational on in_instr; the result is captured on transfer (in_valid & in_ready).
- Opcode map:
  - I: 0000011, 0010011, 1100111, and 0011011 (XLEN=64 only).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - NONE, legal, imm=0: 0110011, 0111011 (XLEN=64 only), 0001111, 1110011.
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
- Immediates, sign bit is always instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Shift-immediate forms get no special treatment; the ALU masks the shamt.
- Storage: output register (OR) plus one skid register (SK).
- Latency: accepted in cycle N, presented on out_* in cycle N+1 when the buffer was empty.
- in_ready = !SK.valid, a registered signal only, with no combinational path from out_ready.
- Transfer cases, given OR holds an entry and out_ready=0:
  - New accept goes to SK, and in_ready drops next cycle.
  - When OR drains and SK is full: SK moves to OR and SK clears.
  - Simultaneous accept and drain with SK empty: the new entry goes to OR directly.
- Ordering is strictly FIFO. While out_valid=1 and out_ready=0, out_* holds stable.
- flush (priority over everything except reset):
  - Next cycle: OR.valid=0, SK.valid=0, in_ready=1.
  - An input presented in the flush cycle is discarded.
  - out_ready during flush is ignored; the presented entry may be consumed or not.
- Reset, sampled on the clk edge:
  - out_valid=0, SK.valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Reset mid-stream discards all entries.
- Data registers load only on capture (no X-propagation onto out_* after reset).

Test Plan:
- Reset then in 0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1, out_illegal=0.
- Stream three back-to-back instructions:
  - 0xFE112E23 (sw -4) -> imm 0xFFFFFFFFFFFFFFFC, fmt 2.
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFFFFFFFFFF8, fmt 3.
  - 0x001000EF (jal +2048) -> imm 0x0000000000000800, fmt 5.
  - Expect one result per cycle, in_ready constantly 1.
- 0x800002B7 (lui 0x80000) -> XLEN=64: 0xFFFFFFFF80000000, fmt 4. XLEN=32: 0x80000000. Opcode 0011011 with XLEN=32 -> illegal=1.
- Backpressure: hold out_ready=0 and offer A, B, C -> A in OR, B in SK, in_ready=0, C held upstream. Then release out_ready -> A, B, C emerge in order with out_* stable while stalled.
- Flush with OR and SK full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears. Same check with reset instead of flush -> all outputs 0.
- Opcode 0x0000007F and instr[1:0]=00 -> out_illegal=1, out_fmt=0, out_imm=0. 0x00000033 (add) -> illegal=0, fmt=0.
